// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: FSM state encoding,
// default widths and the decode-side bubble instruction.
package fetch_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 64;
    localparam int unsigned INST_WIDTH_DEF = 32;

    // addi x0, x0, 0 -- inserted by decode when no instruction is held
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        HOLD,
        HALT
    } fetch_state_t;

    // Instruction addresses must be word aligned
    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Response watchdog for instruction_fetch: a clear/enable counter that
// saturates at TIMEOUT_CYCLES-1 and flags that terminal count.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;

    assign terminal = (wd_cnt == LAST);

    // Count while enabled; hold at the terminal value so it never wraps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (clear) begin
            wd_cnt <= '0;
        end else if (enable && !terminal) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests the word at pc_current from a
// variable-latency memory, holds it for decode and raises pc_advance when
// it is consumed. Redirect flushes discard held or in-flight data; a
// watchdog halts the stage if a response never arrives.
// Optional build macro FETCH_ALIGN_CHECK_EN: refuse misaligned PCs and halt.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned INST_WIDTH     = INST_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_current,
    output logic                  pc_advance,
    input  logic                  flush,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  fetch_fault
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  req_fire;
    logic                  wd_clear;
    logic                  wd_enable;
    logic                  wd_terminal;

    // Request side: only REQ presents an address
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        if (state == REQ) begin
            imem_req_addr = pc_current;
`ifdef FETCH_ALIGN_CHECK_EN
            imem_req_valid = is_word_aligned(pc_current[1:0]);
`else
            imem_req_valid = 1'b1;
`endif
        end
    end

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign wd_clear  = (state == REQ) && req_fire;
    assign wd_enable = (state == WAIT) || (state == DRAIN);

    // Consumption pulse; a flush in the same cycle wins over inst_ready
    assign pc_advance = (state == HOLD) && inst_ready && !flush;

    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .terminal(wd_terminal)
    );

    // Fetch FSM with registered instruction, PC tag, valid and fault
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            inst        <= '0;
            inst_pc     <= '0;
            inst_valid  <= 1'b0;
            req_pc      <= '0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;

                REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (!is_word_aligned(pc_current[1:0])) begin
                        fetch_fault <= 1'b1;
                        state       <= HALT;
                    end else
`endif
                    if (req_fire) begin
                        req_pc <= pc_current;
                        // A flush alongside acceptance means the reply is stale
                        state  <= flush ? DRAIN : WAIT;
                    end
                end

                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (flush) begin
                            state <= REQ;
                        end else begin
                            inst       <= imem_rsp_data;
                            inst_pc    <= req_pc;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (wd_terminal) begin
                        fetch_fault <= 1'b1;
                        state       <= HALT;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state <= REQ;
                    end else if (wd_terminal) begin
                        fetch_fault <= 1'b1;
                        state       <= HALT;
                    end
                end

                HOLD: begin
                    if (flush || inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                end

                HALT: state <= HALT;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a directed per-cycle vector
// table, hand sequences for flush/watchdog/reset/alignment corners, and a
// randomized run against a transaction-level model of the fetch contract.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc_current = '0;
    logic        pc_advance;
    logic        flush = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    instruction_fetch #(
        .ADDR_WIDTH    (64),
        .INST_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_current    (pc_current),
        .pc_advance    (pc_advance),
        .flush         (flush),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .fetch_fault   (fetch_fault)
    );

    typedef struct {
        logic [63:0] pc;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        fl;
        logic        ir;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [63:0] e_ipc;
        logic [31:0] e_inst;
        logic        e_adv;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [63:0] pc, input logic rdy, rv, input logic [31:0] rd,
                       input logic fl, ir, e_req, input logic [63:0] e_addr,
                       input logic e_iv, input logic [63:0] e_ipc, input logic [31:0] e_inst,
                       input logic e_adv);
        vec_t v;
        v.pc = pc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.fl = fl; v.ir = ir;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
        v.e_inst = e_inst; v.e_adv = e_adv;
        tbl.push_back(v);
    endtask

    // Called at a falling edge: drive this cycle's inputs, settle, then check
    task automatic apply(input logic [63:0] p, input logic r, rv, input logic [31:0] rd,
                         input logic fl, ir);
        pc_current     = p;
        imem_req_ready = r;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        flush          = fl;
        inst_ready     = ir;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic reset_dut(input logic [63:0] p);
        reset = 1'b1;
        apply(p, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_valid"}, imem_req_valid, 0);
        check({tag, " req_addr"}, imem_req_addr, 0);
        check({tag, " inst_valid"}, inst_valid, 0);
        check({tag, " inst"}, inst, 0);
        check({tag, " inst_pc"}, inst_pc, 0);
        check({tag, " pc_advance"}, pc_advance, 0);
        check({tag, " fetch_fault"}, fetch_fault, 0);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    // Transaction-level model state for the randomized run
    logic [63:0] pc_m, out_addr, held_pc, tgt;
    logic [31:0] held_data, r_rd;
    logic        started, outst, out_flushed, held;
    logic        r_ready, r_flush, r_ir, r_rv, e_req, accepted;
    int unsigned out_lat;

    initial begin
        // ---------------- reset values ----------------
        reset_dut(64'h0);
        reset = 1'b1;
        apply(64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_all_zero("reset");

        // ---------------- directed vector table ----------------
        //   pc       rdy rv data          fl ir  req addr     iv ipc      inst          adv
        add(64'h0,    1, 0, 32'h0,         0, 1,  0, 64'h0,    0, 64'h0,   32'h0,         0); // IDLE
        add(64'h0,    1, 0, 32'h0,         0, 1,  1, 64'h0,    0, 64'h0,   32'h0,         0); // REQ
        add(64'h0,    1, 1, 32'hA000_0000, 0, 1,  0, 64'h0,    0, 64'h0,   32'h0,         0); // WAIT
        add(64'h0,    1, 0, 32'h0,         0, 1,  0, 64'h0,    1, 64'h0,   32'hA000_0000, 1); // HOLD
        add(64'h4,    1, 0, 32'h0,         0, 1,  1, 64'h4,    0, 64'h0,   32'h0,         0);
        add(64'h4,    1, 1, 32'hA000_0004, 0, 1,  0, 64'h0,    0, 64'h0,   32'h0,         0);
        add(64'h4,    1, 0, 32'h0,         0, 1,  0, 64'h0,    1, 64'h4,   32'hA000_0004, 1);
        add(64'h8,    1, 0, 32'h0,         0, 1,  1, 64'h8,    0, 64'h0,   32'h0,         0);
        add(64'h8,    1, 1, 32'hA000_0008, 0, 1,  0, 64'h0,    0, 64'h0,   32'h0,         0);
        add(64'h8,    1, 0, 32'h0,         0, 1,  0, 64'h0,    1, 64'h8,   32'hA000_0008, 1);
        // decode stalls five cycles in HOLD
        add(64'hC,    1, 0, 32'h0,         0, 0,  1, 64'hC,    0, 64'h0,   32'h0,         0);
        add(64'hC,    1, 1, 32'hA000_000C, 0, 0,  0, 64'h0,    0, 64'h0,   32'h0,         0);
        for (int k = 0; k < 5; k++)
            add(64'hC, 1, 0, 32'h0,        0, 0,  0, 64'h0,    1, 64'hC,   32'hA000_000C, 0);
        add(64'hC,    1, 0, 32'h0,         0, 1,  0, 64'h0,    1, 64'hC,   32'hA000_000C, 1);
        // redirect in REQ, then memory back-pressure for four cycles
        add(64'h10,   0, 0, 32'h0,         1, 0,  1, 64'h10,   0, 64'h0,   32'h0,         0);
        for (int k = 0; k < 3; k++)
            add(64'h1000, 0, 0, 32'h0,     0, 0,  1, 64'h1000, 0, 64'h0,   32'h0,         0);
        add(64'h1000, 1, 0, 32'h0,         0, 0,  1, 64'h1000, 0, 64'h0,   32'h0,         0);
        add(64'h1000, 1, 0, 32'h0,         0, 0,  0, 64'h0,    0, 64'h0,   32'h0,         0);
        add(64'h1000, 1, 0, 32'h0,         0, 0,  0, 64'h0,    0, 64'h0,   32'h0,         0);
        add(64'h1000, 1, 1, 32'hA000_1000, 0, 0,  0, 64'h0,    0, 64'h0,   32'h0,         0);
        add(64'h1000, 1, 0, 32'h0,         0, 1,  0, 64'h0,    1, 64'h1000, 32'hA000_1000, 1);
        add(64'h1004, 0, 0, 32'h0,         0, 0,  1, 64'h1004, 0, 64'h0,   32'h0,         0);

        reset_dut(64'h0);
        foreach (tbl[i]) begin
            apply(tbl[i].pc, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].fl, tbl[i].ir);
            check($sformatf("vec%0d req_valid", i), imem_req_valid, tbl[i].e_req);
            check($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
            check($sformatf("vec%0d inst_valid", i), inst_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                check($sformatf("vec%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
                check($sformatf("vec%0d inst", i), inst, tbl[i].e_inst);
            end
            check($sformatf("vec%0d pc_advance", i), pc_advance, tbl[i].e_adv);
            check($sformatf("vec%0d fetch_fault", i), fetch_fault, 0);
            next_cycle();
        end

        // ---------------- flush in WAIT discards in-flight data ----------------
        reset_dut(64'h20);
        apply(64'h20, 1, 0, 32'h0, 0, 0);                 // IDLE
        next_cycle();
        apply(64'h20, 1, 0, 32'h0, 0, 0);                 // REQ accepted
        check("fl req_addr", imem_req_addr, 64'h20);
        next_cycle();
        apply(64'h20, 0, 0, 32'h0, 1, 0);                 // WAIT, redirect
        check("fl wait req_valid", imem_req_valid, 0);
        next_cycle();
        apply(64'h1000, 1, 0, 32'h0, 0, 1);               // DRAIN
        check("fl drain req_valid", imem_req_valid, 0);
        next_cycle();
        apply(64'h1000, 1, 1, 32'hDEAD_BEEF, 0, 1);       // stale reply
        check("fl drain2 req_valid", imem_req_valid, 0);
        check("fl drain2 inst_valid", inst_valid, 0);
        next_cycle();
        apply(64'h1000, 1, 0, 32'h0, 0, 1);
        check("fl reissue req_valid", imem_req_valid, 1);
        check("fl reissue req_addr", imem_req_addr, 64'h1000);
        check("fl reissue inst_valid", inst_valid, 0);
        next_cycle();
        apply(64'h1000, 1, 1, 32'h1111_1111, 0, 1);
        next_cycle();
        apply(64'h1000, 0, 0, 32'h0, 0, 1);
        check("fl hold inst_valid", inst_valid, 1);
        check("fl hold inst", inst, 32'h1111_1111);
        check("fl hold inst_pc", inst_pc, 64'h1000);
        check("fl hold pc_advance", pc_advance, 1);
        next_cycle();

        // ---------------- watchdog, HALT and async reset ----------------
        reset_dut(64'h40);
        apply(64'h40, 1, 0, 32'h0, 0, 0);
        next_cycle();
        apply(64'h40, 1, 0, 32'h0, 0, 0);                 // REQ accepted
        check("wd req_valid", imem_req_valid, 1);
        next_cycle();
        for (int k = 0; k < 16; k++) begin
            apply(64'h40, 1, 0, 32'h0, 0, 1);
            check($sformatf("wd wait%0d fetch_fault", k), fetch_fault, 0);
            next_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            apply(64'h40, 1, 1, 32'hBAD0_BAD0, (k == 2), 1);
            check($sformatf("halt%0d fetch_fault", k), fetch_fault, 1);
            check($sformatf("halt%0d req_valid", k), imem_req_valid, 0);
            check($sformatf("halt%0d inst_valid", k), inst_valid, 0);
            check($sformatf("halt%0d pc_advance", k), pc_advance, 0);
            next_cycle();
        end
        reset = 1'b1;                                     // asserted between edges
        apply(64'h80, 1, 0, 32'h0, 0, 1);
        check_all_zero("async reset");
        next_cycle();
        reset = 1'b0;
        apply(64'h80, 1, 0, 32'h0, 0, 1);
        check("restart idle req_valid", imem_req_valid, 0);
        next_cycle();
        apply(64'h80, 1, 0, 32'h0, 0, 1);
        check("restart req_valid", imem_req_valid, 1);
        check("restart req_addr", imem_req_addr, 64'h80);
        next_cycle();
        apply(64'h80, 1, 1, 32'h5555_AAAA, 0, 1);
        next_cycle();
        apply(64'h80, 1, 0, 32'h0, 0, 1);
        check("restart inst", inst, 32'h5555_AAAA);
        check("restart inst_pc", inst_pc, 64'h80);
        next_cycle();

        // ---------------- misaligned PC ----------------
        reset_dut(64'h1002);
        apply(64'h1002, 0, 0, 32'h0, 0, 0);
        next_cycle();
        apply(64'h1002, 0, 0, 32'h0, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("align req_valid", imem_req_valid, 0);
        next_cycle();
        apply(64'h1002, 1, 0, 32'h0, 0, 0);
        check("align fetch_fault", fetch_fault, 1);
        check("align halt req_valid", imem_req_valid, 0);
`else
        check("align req_valid", imem_req_valid, 1);
        check("align req_addr", imem_req_addr, 64'h1002);
        next_cycle();
        apply(64'h1002, 0, 0, 32'h0, 0, 0);
        check("align fetch_fault", fetch_fault, 0);
        check("align still req", imem_req_valid, 1);
`endif
        next_cycle();

        // ---------------- randomized run vs. transaction model ----------------
        reset_dut(64'h0);
        pc_m = 64'h0; started = 0; outst = 0; held = 0;
        out_addr = '0; out_flushed = 0; out_lat = 0; held_pc = '0; held_data = '0;
        for (int c = 0; c < 400; c++) begin
            r_ready = ($urandom_range(99, 0) < 60);
            r_flush = ($urandom_range(99, 0) < 12);
            r_ir    = ($urandom_range(1, 0) == 1);
            tgt     = {32'h0, $urandom() & 32'hFFFF_FFFC};
            if (outst && out_lat == 0) begin
                r_rv = 1; r_rd = mem_word(out_addr);
            end else if (!outst && $urandom_range(99, 0) < 5) begin
                r_rv = 1; r_rd = 32'hBAD0_BAD0;
            end else begin
                r_rv = 0; r_rd = $urandom();
            end
            e_req = started && !outst && !held;
            apply(pc_m, r_ready, r_rv, r_rd, r_flush, r_ir);
            check($sformatf("rnd%0d req_valid", c), imem_req_valid, e_req);
            check($sformatf("rnd%0d req_addr", c), imem_req_addr, e_req ? pc_m : 64'h0);
            check($sformatf("rnd%0d inst_valid", c), inst_valid, held);
            if (held) begin
                check($sformatf("rnd%0d inst", c), inst, held_data);
                check($sformatf("rnd%0d inst_pc", c), inst_pc, held_pc);
            end
            check($sformatf("rnd%0d pc_advance", c), pc_advance, held && r_ir && !r_flush);
            check($sformatf("rnd%0d fetch_fault", c), fetch_fault, 0);

            accepted = e_req && r_ready;
            if (outst) begin
                if (out_lat == 0) begin
                    if (!out_flushed && !r_flush) begin
                        held = 1; held_pc = out_addr; held_data = mem_word(out_addr);
                    end
                    outst = 0;
                end else begin
                    if (r_flush) out_flushed = 1;
                    out_lat--;
                end
            end else if (held) begin
                if (r_flush) held = 0;
                else if (r_ir) begin
                    held = 0; pc_m = pc_m + 64'd4;
                end
            end
            if (accepted) begin
                outst = 1; out_addr = pc_m; out_flushed = r_flush;
                out_lat = $urandom_range(3, 0);
            end
            if (r_flush) pc_m = tgt;
            started = 1;
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
